approx_mul8_seq: RTL

APPROX_MUL8_SEQ -- requirements
Module: approx_mul8_seq

---
 rtl/approx_mul8_seq_pkg.sv | 23 ++
 rtl/approx_multiplier.sv | 29 ++
 rtl/approx_mul8_seq.sv | 103 ++++++++++
 3 files changed

// File: rtl/approx_mul8_seq_pkg.sv
// Shared types and constants for the sequential 8x8 approximate multiplier.
// Holds the FSM state enum, datapath widths and the per-pass shift table.
// Pass k (k = cnt) multiplies one nibble pair and shifts the product left by pass_shift(k).
package approx_mul8_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB_W = 4;
    localparam int OP_W  = 8;
    localparam int P_W   = 16;

    // Shift per pass, packed low pass first: {cnt3, cnt2, cnt1, cnt0} = {8, 4, 4, 0}
    localparam logic [15:0] PASS_SHIFT_TBL = {4'd8, 4'd4, 4'd4, 4'd0};

    function automatic logic [3:0] pass_shift(input logic [1:0] c);
        return PASS_SHIFT_TBL[{c, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/approx_multiplier.sv
// 4x4 approximate unsigned multiplier, purely combinational.
// Ports: a, b (4-bit operands); p (8-bit product, declared [0:7], index 7 is the LSB).
// Approximation: the weight-2 column ORs its two partial products, so the carry is lost.
module approx_multiplier (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [0:7] p
);

    logic [7:0] sum;
    logic       col1;

    always_comb begin
        sum  = 8'd0;
        col1 = (a[1] & b[0]) | (a[0] & b[1]);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (i + j != 1) begin
                    sum = sum + ({7'd0, a[i] & b[j]} << (i + j));
                end
            end
        end
        sum = sum + {6'd0, col1, 1'b0};
    end

    // Positional assignment: sum[7] lands on p[0], sum[0] lands on p[7].
    assign p = sum;

endmodule

// File: rtl/approx_mul8_seq.sv
// Sequential 8x8 approximate multiplier: four nibble passes through one shared 4x4 core.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/a/b operand handshake;
//        out_valid/out_ready/p result handshake (p registered); busy = not IDLE.
// Latency: result valid 4 edges after accept; holds in DONE until out_ready.
module approx_mul8_seq
    import approx_mul8_seq_pkg::*;
#(
    parameter int LOW_EXACT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] p,
    output logic        busy
);

    state_t              state;
    logic [1:0]          cnt;
    logic [OP_W-1:0]     a_r;
    logic [OP_W-1:0]     b_r;
    logic [P_W-1:0]      acc;

    logic [NIB_W-1:0]    nib_a;
    logic [NIB_W-1:0]    nib_b;
    logic [0:7]          core_raw;
    logic [7:0]          core_prod;
    logic [7:0]          exact_prod;
    logic [7:0]          pass_prod;
    logic [P_W-1:0]      addend;
    logic [P_W-1:0]      acc_nxt;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // cnt[0] picks the high nibble of a, cnt[1] the high nibble of b.
    assign nib_a = cnt[0] ? a_r[7:4] : a_r[3:0];
    assign nib_b = cnt[1] ? b_r[7:4] : b_r[3:0];

    approx_multiplier u_core (
        .a (nib_a),
        .b (nib_b),
        .p (core_raw)
    );

    // Core output counts its LSB at index 7; flip into a [7:0] value.
    always_comb begin
        core_prod = 8'd0;
        for (int k = 0; k < 8; k++) begin
            core_prod[k] = core_raw[7-k];
        end
    end

    assign exact_prod = {4'd0, nib_a} * {4'd0, nib_b};
    assign pass_prod  = ((LOW_EXACT != 0) && (cnt == 2'd0)) ? exact_prod : core_prod;
    assign addend     = {8'd0, pass_prod} << pass_shift(cnt);
    assign acc_nxt    = acc + addend;   // wraps modulo 2^16

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            a_r       <= '0;
            b_r       <= '0;
            acc       <= '0;
            p         <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        acc   <= '0;
                        cnt   <= 2'd0;
                        state <= MUL;
                    end
                end
                MUL: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        p         <= acc_nxt;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
